// File: rtl/mux_sched_ctrl.sv
// Scheduler for the shared 3:1 sample mux feeding the filter datapath.
// Picks one of three requesters (round-robin or fixed priority), drives the
// mux select, captures the muxed sample, and hands it downstream over a
// valid/ready handshake. Each served requester gets a one-cycle one-hot ack.
module mux_sched_ctrl #(
    parameter int SIZE = 21
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            mode,
    input  logic [2:0]      req,
    input  logic [SIZE-1:0] mux_data,
    output logic [1:0]      select,
    output logic [SIZE-1:0] dato_out,
    output logic            valid_out,
    input  logic            ready_in,
    output logic [2:0]      ack,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SEND   = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t            state_q;
    logic [1:0]        select_q;
    logic [SIZE-1:0]   dato_q;
    logic              valid_q;
    logic [2:0]        ack_q;
    logic              busy_q;
    logic [1:0]        winner_q;
    logic [1:0]        rr_ptr_q;

    logic [1:0]        winner_d;
    logic [1:0]        rr_ptr_d;

    // First set request bit, scanning the three sources in the order a, b, c.
    function automatic logic [1:0] first_set(input logic [2:0] r,
                                             input logic [1:0] a,
                                             input logic [1:0] b,
                                             input logic [1:0] c);
        if (r[a])
            first_set = a;
        else if (r[b])
            first_set = b;
        else
            first_set = c;
    endfunction

    // Winner selection: fixed priority A>B>C, or round-robin starting at rr_ptr.
    always_comb begin
        winner_d = 2'd0;
        if (mode) begin
            winner_d = first_set(req, 2'd0, 2'd1, 2'd2);
        end else begin
            case (rr_ptr_q)
                2'd1:    winner_d = first_set(req, 2'd1, 2'd2, 2'd0);
                2'd2:    winner_d = first_set(req, 2'd2, 2'd0, 2'd1);
                default: winner_d = first_set(req, 2'd0, 2'd1, 2'd2);
            endcase
        end
    end

    // Pointer moves just past the source that was served; wraps C -> A.
    always_comb begin
        rr_ptr_d = (winner_q == 2'd2) ? 2'd0 : winner_q + 2'd1;
    end

    // Transfer FSM; every output is a register so select never glitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            select_q <= 2'b00;
            dato_q   <= '0;
            valid_q  <= 1'b0;
            ack_q    <= 3'b000;
            busy_q   <= 1'b0;
            winner_q <= 2'd0;
            rr_ptr_q <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && (req != 3'b000)) begin
                        select_q <= winner_d;
                        winner_q <= winner_d;
                        busy_q   <= 1'b1;
                        state_q  <= SETTLE;
                    end
                end
                SETTLE: begin
                    // select has been stable a full cycle, so mux_data is settled
                    dato_q  <= mux_data;
                    valid_q <= 1'b1;
                    state_q <= SEND;
                end
                SEND: begin
                    if (valid_q && ready_in) begin
                        valid_q <= 1'b0;
                        ack_q   <= 3'b001 << winner_q;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    ack_q    <= 3'b000;
                    rr_ptr_q <= rr_ptr_d;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign select    = select_q;
    assign dato_out  = dato_q;
    assign valid_out = valid_q;
    assign ack       = ack_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mux_sched_ctrl.sv
// Directed bench for mux_sched_ctrl: reset, single transfer, round-robin,
// fixed priority, backpressure, reset abort and enable drop.
module tb_mux_sched_ctrl;

    localparam int SIZE = 21;

    logic            clk;
    logic            reset_n;
    logic            enable;
    logic            mode;
    logic [2:0]      req;
    logic [SIZE-1:0] mux_data;
    logic [1:0]      select;
    logic [SIZE-1:0] dato_out;
    logic            valid_out;
    logic            ready_in;
    logic [2:0]      ack;
    logic            busy;

    int n_cmp;
    int n_bad;

    mux_sched_ctrl #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .mode      (mode),
        .req       (req),
        .mux_data  (mux_data),
        .select    (select),
        .dato_out  (dato_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .ack       (ack),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run until an ack pulse appears (bounded), check it, then step past ACK.
    task automatic expect_ack(input string tag, input logic [2:0] exp);
        for (int i = 0; i < 20; i++) begin
            if (ack != 3'b000) break;
            tick();
        end
        check_val(tag, {29'd0, ack}, {29'd0, exp});
        tick();
        check_val({tag, "_clr"}, {29'd0, ack}, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [SIZE-1:0] held;
        n_cmp    = 0;
        n_bad    = 0;
        reset_n  = 1'b1;
        enable   = 1'b1;
        mode     = 1'b0;
        req      = 3'b111;
        mux_data = 21'h12345;
        ready_in = 1'b1;
        #2;

        // 1. Reset asserted with all requests active: outputs held at reset values.
        reset_n = 1'b0;
        #1;
        tick();
        tick();
        tick();
        check_val("rst_select", {30'd0, select}, 32'd0);
        check_val("rst_valid",  {31'd0, valid_out}, 32'd0);
        check_val("rst_ack",    {29'd0, ack}, 32'd0);
        check_val("rst_busy",   {31'd0, busy}, 32'd0);
        check_val("rst_dato",   {11'd0, dato_out}, 32'd0);

        // 2. Single request from B, round-robin mode; req dropped after grant.
        req      = 3'b010;
        mux_data = 21'h0ABCD;
        reset_n  = 1'b1;
        tick();                     // edge 1: grant
        check_val("s_select", {30'd0, select}, 32'd1);
        check_val("s_busy1",  {31'd0, busy}, 32'd1);
        check_val("s_valid0", {31'd0, valid_out}, 32'd0);
        req = 3'b000;
        tick();                     // edge 2: sample captured
        check_val("s_dato",   {11'd0, dato_out}, 32'h0ABCD);
        check_val("s_valid1", {31'd0, valid_out}, 32'd1);
        tick();                     // edge 3: ack pulse
        check_val("s_ack",    {29'd0, ack}, 32'b010);
        check_val("s_valid2", {31'd0, valid_out}, 32'd0);
        tick();                     // edge 4: back to IDLE
        check_val("s_ack_clr", {29'd0, ack}, 32'd0);
        check_val("s_busy0",  {31'd0, busy}, 32'd0);
        tick();
        check_val("s_idle_sel", {30'd0, select}, 32'd1);

        // 3. Round-robin from a fresh pointer with all requests held.
        do_reset();
        req = 3'b111;
        expect_ack("rr_A0", 3'b001);
        expect_ack("rr_B",  3'b010);
        expect_ack("rr_C",  3'b100);
        expect_ack("rr_A1", 3'b001);

        // 4. Fixed priority: A wins every time.
        mode = 1'b1;
        for (int k = 0; k < 3; k++) expect_ack("fp_A", 3'b001);
        mode = 1'b0;
        req  = 3'b000;
        tick();
        tick();

        // 5. Backpressure: five cycles of ready_in=0 after valid rises.
        ready_in = 1'b0;
        req      = 3'b100;
        mux_data = 21'h1F00F;
        for (int i = 0; i < 20; i++) begin
            if (valid_out) break;
            tick();
        end
        check_val("bp_valid_rise", {31'd0, valid_out}, 32'd1);
        held     = dato_out;
        check_val("bp_dato", {11'd0, held}, 32'h1F00F);
        mux_data = 21'h00777;
        req      = 3'b000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("bp_hold_dato",  {11'd0, dato_out}, {11'd0, held});
            check_val("bp_hold_valid", {31'd0, valid_out}, 32'd1);
            check_val("bp_hold_ack",   {29'd0, ack}, 32'd0);
            check_val("bp_hold_busy",  {31'd0, busy}, 32'd1);
        end
        ready_in = 1'b1;
        tick();
        check_val("bp_ack",   {29'd0, ack}, 32'b100);
        check_val("bp_valid", {31'd0, valid_out}, 32'd0);
        tick();
        check_val("bp_ack_clr", {29'd0, ack}, 32'd0);

        // 6a. Reset pulsed during SEND: immediate reset values, no ack.
        ready_in = 1'b0;
        req      = 3'b010;
        for (int i = 0; i < 20; i++) begin
            if (valid_out) break;
            tick();
        end
        check_val("ab_in_send", {31'd0, valid_out}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("ab_valid",  {31'd0, valid_out}, 32'd0);
        check_val("ab_busy",   {31'd0, busy}, 32'd0);
        check_val("ab_select", {30'd0, select}, 32'd0);
        check_val("ab_dato",   {11'd0, dato_out}, 32'd0);
        ready_in = 1'b1;
        tick();
        tick();
        check_val("ab_ack", {29'd0, ack}, 32'd0);
        req     = 3'b000;
        reset_n = 1'b1;
        tick();

        // 6b. enable dropped during SETTLE: transfer completes, then stays idle.
        req    = 3'b111;
        enable = 1'b1;
        tick();                     // grant A (pointer is 0 after reset)
        check_val("en_grant", {30'd0, select}, 32'd0);
        enable = 1'b0;
        tick();                     // SEND
        check_val("en_valid", {31'd0, valid_out}, 32'd1);
        tick();                     // ACK
        check_val("en_ack", {29'd0, ack}, 32'b001);
        tick();
        tick();
        tick();
        check_val("en_busy_off", {31'd0, busy}, 32'd0);
        check_val("en_no_valid", {31'd0, valid_out}, 32'd0);
        check_val("en_no_ack",   {29'd0, ack}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
